// File: rtl/step_motor_ramp_ctrl_if.sv
// rtl/step_motor_ramp_ctrl_if.sv - Avalon-MM control bus bundle for the step motor ramp controller
interface step_motor_ramp_ctrl_if;
   logic [2:0]  avs_ctrl_address;
   logic [31:0] avs_ctrl_writedata;
   logic [3:0]  avs_ctrl_byteenable;
   logic        avs_ctrl_write;
   logic        avs_ctrl_read;
   logic [31:0] avs_ctrl_readdata;
   logic        avs_ctrl_waitrequest;

   modport master (
      output avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
      output avs_ctrl_write, avs_ctrl_read,
      input  avs_ctrl_readdata, avs_ctrl_waitrequest
   );

   modport slave (
      input  avs_ctrl_address, avs_ctrl_writedata, avs_ctrl_byteenable,
      input  avs_ctrl_write, avs_ctrl_read,
      output avs_ctrl_readdata, avs_ctrl_waitrequest
   );
endinterface

// File: rtl/step_motor_ramp_ctrl.sv
// rtl/step_motor_ramp_ctrl.sv - step/dir pulse sequencer with trapezoidal period ramp
// Periods are in clock cycles; a smaller period means a faster step rate.
module step_motor_ramp_ctrl #(
   parameter int PULSE_W  = 4,
   parameter int PERIOD_W = 32
) (
   input  logic                   csi_MCLK_clk,
   input  logic                   rsi_MRST_reset,
   step_motor_ramp_ctrl_if.slave  avs,
   output logic                   step_out,
   output logic                   dir_out,
   output logic                   busy,
   output logic                   irq
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCEL  = 2'd1,
      S_CRUISE = 2'd2,
      S_DECEL  = 2'd3
   } state_t;

   typedef logic [PERIOD_W-1:0] per_t;

   localparam per_t FLOOR = per_t'(PULSE_W + 1);
   localparam per_t PW    = per_t'(PULSE_W);
   localparam per_t ONE   = per_t'(1);

   state_t      state_q, state_d;
   per_t        steps_q, steps_d;
   per_t        start_period_q, start_period_d;
   per_t        min_period_q, min_period_d;
   per_t        accel_q, accel_d;
   per_t        period_q, period_d;
   per_t        cyc_q, cyc_d;
   per_t        pos_q, pos_d;
   per_t        accel_cnt_q, accel_cnt_d;
   per_t        p0_q, p0_d;
   per_t        pmin_q, pmin_d;
   logic        irq_en_q, irq_en_d;
   logic        done_q, done_d;
   logic        dir_q, dir_d;
   logic        busy_q, busy_d;
   logic        step_q, step_d;
   logic [31:0] rdata_q, rdata_d;

   logic            wr_ctrl, start_cmd, abort_cmd;
   per_t            p0_w, pm_w, pmin_w, rem, per_inc, per_dec;
   logic [PERIOD_W:0] sum_w, diff_w;

   function automatic per_t be_merge(input per_t cur, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] v;
      v = 32'(cur);
      for (int i = 0; i < 4; i++) begin
         if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
      end
      return per_t'(v);
   endfunction

   always_comb begin
      state_d        = state_q;
      steps_d        = steps_q;
      start_period_d = start_period_q;
      min_period_d   = min_period_q;
      accel_d        = accel_q;
      period_d       = period_q;
      cyc_d          = cyc_q;
      pos_d          = pos_q;
      accel_cnt_d    = accel_cnt_q;
      p0_d           = p0_q;
      pmin_d         = pmin_q;
      irq_en_d       = irq_en_q;
      done_d         = done_q;
      dir_d          = dir_q;
      busy_d         = busy_q;
      step_d         = step_q;
      rdata_d        = rdata_q;

      wr_ctrl   = avs.avs_ctrl_write && (avs.avs_ctrl_address == 3'd0);
      start_cmd = wr_ctrl && avs.avs_ctrl_writedata[0];
      abort_cmd = wr_ctrl && avs.avs_ctrl_writedata[2];

      p0_w   = (start_period_q < FLOOR) ? FLOOR : start_period_q;
      pm_w   = (min_period_q < FLOOR) ? FLOOR : min_period_q;
      pmin_w = (pm_w > p0_w) ? p0_w : pm_w;

      // Widened by one bit so neither ramp direction can wrap before saturating.
      sum_w   = {1'b0, period_q} + {1'b0, accel_q};
      diff_w  = {1'b0, period_q} - {1'b0, accel_q};
      per_inc = (sum_w > {1'b0, p0_q}) ? p0_q : sum_w[PERIOD_W-1:0];
      per_dec = (diff_w[PERIOD_W] || (diff_w[PERIOD_W-1:0] < pmin_q)) ? pmin_q : diff_w[PERIOD_W-1:0];
      rem     = steps_q - pos_q;

      if (wr_ctrl) irq_en_d = avs.avs_ctrl_writedata[3];
      if (avs.avs_ctrl_write && (avs.avs_ctrl_address == 3'd5) && avs.avs_ctrl_writedata[1])
         done_d = 1'b0;

      if (avs.avs_ctrl_write && !busy_q) begin
         case (avs.avs_ctrl_address)
            3'd1: steps_d        = be_merge(steps_q, avs.avs_ctrl_writedata, avs.avs_ctrl_byteenable);
            3'd2: start_period_d = be_merge(start_period_q, avs.avs_ctrl_writedata, avs.avs_ctrl_byteenable);
            3'd3: min_period_d   = be_merge(min_period_q, avs.avs_ctrl_writedata, avs.avs_ctrl_byteenable);
            3'd4: accel_d        = be_merge(accel_q, avs.avs_ctrl_writedata, avs.avs_ctrl_byteenable);
            default: ;
         endcase
      end

      if (avs.avs_ctrl_read) begin
         case (avs.avs_ctrl_address)
            3'd0: rdata_d = {28'd0, irq_en_q, 3'd0};
            3'd1: rdata_d = 32'(steps_q);
            3'd2: rdata_d = 32'(start_period_q);
            3'd3: rdata_d = 32'(min_period_q);
            3'd4: rdata_d = 32'(accel_q);
            3'd5: rdata_d = {28'd0, state_q, done_q, busy_q};
            3'd6: rdata_d = 32'(pos_q);
            default: rdata_d = 32'd0;
         endcase
      end

      if (abort_cmd) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         step_d  = 1'b0;
         done_d  = 1'b1;
      end else if (state_q == S_IDLE) begin
         if (start_cmd) begin
            if (steps_q == '0) begin
               done_d = 1'b1;
               pos_d  = '0;
            end else begin
               state_d     = S_ACCEL;
               p0_d        = p0_w;
               pmin_d      = pmin_w;
               period_d    = p0_w;
               cyc_d       = '0;
               pos_d       = ONE;
               accel_cnt_d = '0;
               dir_d       = avs.avs_ctrl_writedata[1];
               busy_d      = 1'b1;
               step_d      = 1'b1;
            end
         end
      end else if (cyc_q == period_q - ONE) begin
         if (rem == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            step_d  = 1'b0;
         end else begin
            pos_d  = pos_q + ONE;
            cyc_d  = '0;
            step_d = 1'b1;
            // Deceleration begins once the remaining steps match the steps spent accelerating.
            case (state_q)
               S_ACCEL: begin
                  if (rem <= accel_cnt_q) begin
                     state_d  = S_DECEL;
                     period_d = per_inc;
                  end else begin
                     period_d    = per_dec;
                     accel_cnt_d = accel_cnt_q + ONE;
                     if (per_dec == pmin_q) state_d = S_CRUISE;
                  end
               end
               S_CRUISE: begin
                  if (rem <= accel_cnt_q) begin
                     state_d  = S_DECEL;
                     period_d = per_inc;
                  end
               end
               default: period_d = per_inc;
            endcase
         end
      end else begin
         cyc_d  = cyc_q + ONE;
         step_d = ((cyc_q + ONE) < PW);
      end
   end

   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         state_q        <= S_IDLE;
         steps_q        <= '0;
         start_period_q <= '0;
         min_period_q   <= '0;
         accel_q        <= '0;
         period_q       <= '0;
         cyc_q          <= '0;
         pos_q          <= '0;
         accel_cnt_q    <= '0;
         p0_q           <= '0;
         pmin_q         <= '0;
         irq_en_q       <= 1'b0;
         done_q         <= 1'b0;
         dir_q          <= 1'b0;
         busy_q         <= 1'b0;
         step_q         <= 1'b0;
         rdata_q        <= '0;
      end else begin
         state_q        <= state_d;
         steps_q        <= steps_d;
         start_period_q <= start_period_d;
         min_period_q   <= min_period_d;
         accel_q        <= accel_d;
         period_q       <= period_d;
         cyc_q          <= cyc_d;
         pos_q          <= pos_d;
         accel_cnt_q    <= accel_cnt_d;
         p0_q           <= p0_d;
         pmin_q         <= pmin_d;
         irq_en_q       <= irq_en_d;
         done_q         <= done_d;
         dir_q          <= dir_d;
         busy_q         <= busy_d;
         step_q         <= step_d;
         rdata_q        <= rdata_d;
      end
   end

   assign step_out                 = step_q;
   assign dir_out                  = dir_q;
   assign busy                     = busy_q;
   assign irq                      = done_q & irq_en_q;
   assign avs.avs_ctrl_readdata    = rdata_q;
   assign avs.avs_ctrl_waitrequest = 1'b0;
endmodule

// File: tb/tb_step_motor_ramp_ctrl.sv
// tb/tb_step_motor_ramp_ctrl.sv - self-checking bench for step_motor_ramp_ctrl
module tb_step_motor_ramp_ctrl;
   localparam int PW = 4;
   localparam longint NEVER = 64'h7fff_ffff_ffff;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic step_out, dir_out, busy, irq;
   int   cyc_n = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   cmp_en = 1'b0;

   // Profile model: per-step periods derived from the ramp rules, plus start/abort times.
   int     m_per[0:63];
   int     m_n = 0;
   longint m_t0 = 0;
   longint m_abort = NEVER;

   step_motor_ramp_ctrl_if bus();

   step_motor_ramp_ctrl #(.PULSE_W(PW), .PERIOD_W(32)) dut (
      .csi_MCLK_clk   (clk),
      .rsi_MRST_reset (rst),
      .avs            (bus.slave),
      .step_out       (step_out),
      .dir_out        (dir_out),
      .busy           (busy),
      .irq            (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic load_model(input longint n, input longint st, input longint mn, input longint ac);
      longint p0, pmin, p, k, r;
      int mode;
      p0   = (st > PW + 1) ? st : PW + 1;
      pmin = (mn > PW + 1) ? mn : PW + 1;
      if (pmin > p0) pmin = p0;
      p = p0; k = 0; mode = 0;
      if (n > 0) m_per[0] = int'(p0);
      for (int s = 1; s < n; s++) begin
         r = n - s;
         if (mode == 2) p = (p + ac > p0) ? p0 : p + ac;
         else if (r <= k) begin
            mode = 2;
            p = (p + ac > p0) ? p0 : p + ac;
         end else if (mode == 0) begin
            p = (p - ac < pmin) ? pmin : p - ac;
            k++;
            if (p == pmin) mode = 1;
         end
         m_per[s] = int'(p);
      end
      m_n = int'(n);
   endtask

   function automatic bit exp_step(input longint c);
      longint off, s;
      if (m_n == 0 || c <= m_t0 || c >= m_abort) return 1'b0;
      off = c - m_t0 - 1;
      s = 0;
      for (int i = 0; i < m_n; i++) begin
         if (off < s + m_per[i]) return ((off - s) < PW);
         s += m_per[i];
      end
      return 1'b0;
   endfunction

   function automatic bit exp_busy(input longint c);
      longint tot;
      if (m_n == 0 || c <= m_t0 || c >= m_abort) return 1'b0;
      tot = 0;
      for (int i = 0; i < m_n; i++) tot += m_per[i];
      return ((c - m_t0 - 1) < tot);
   endfunction

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("step_out_model", step_out, exp_step(cyc_n));
         check("busy_model", busy, exp_busy(cyc_n));
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be, output int edge_c);
      bus.avs_ctrl_address    = a;
      bus.avs_ctrl_writedata  = d;
      bus.avs_ctrl_byteenable = be;
      bus.avs_ctrl_write      = 1'b1;
      @(posedge clk);
      #1;
      edge_c = cyc_n;
      bus.avs_ctrl_write = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      bus.avs_ctrl_address = a;
      bus.avs_ctrl_read    = 1'b1;
      @(posedge clk);
      #1;
      d = bus.avs_ctrl_readdata;
      bus.avs_ctrl_read = 1'b0;
   endtask

   task automatic at_cycle(input longint c);
      while (cyc_n < c) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, ok, 1);
   endtask

   // Programs the profile, clears done, then issues start; returns T (start edge minus one).
   task automatic start_profile(input int n, input int st, input int mn, input int ac, input bit dir, output longint t);
      int e;
      bus_write(3'd1, n, 4'hF, e);
      bus_write(3'd2, st, 4'hF, e);
      bus_write(3'd3, mn, 4'hF, e);
      bus_write(3'd4, ac, 4'hF, e);
      bus_write(3'd5, 32'h2, 4'hF, e);
      bus_write(3'd0, {30'd0, dir, 1'b1}, 4'hF, e);
      t = e - 1;
      m_t0 = t;
      m_abort = NEVER;
      load_model(n, st, mn, ac);
   endtask

   initial begin
      int e;
      longint t;
      logic [31:0] rd;
      int rises[6] = '{1, 101, 171, 211, 251, 321};
      int per1[6]  = '{100, 70, 40, 40, 70, 100};

      bus.avs_ctrl_address    = '0;
      bus.avs_ctrl_writedata  = '0;
      bus.avs_ctrl_byteenable = '0;
      bus.avs_ctrl_write      = 1'b0;
      bus.avs_ctrl_read       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;

      check("rst_step", step_out, 0);
      check("rst_dir", dir_out, 0);
      check("rst_busy", busy, 0);
      check("rst_irq", irq, 0);
      check("rst_readdata", bus.avs_ctrl_readdata, 0);
      check("waitrequest", bus.avs_ctrl_waitrequest, 0);
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), rd);
         check("rst_reg", rd, 0);
      end

      // Case 1: full trapezoid.
      start_profile(6, 100, 40, 30, 1'b1, t);
      for (int i = 0; i < 6; i++) check("model_period", m_per[i], per1[i]);
      for (int i = 0; i < 6; i++) begin
         at_cycle(t + rises[i]);
         check("c1_rise", step_out, 1);
         at_cycle(t + rises[i] + 3);
         check("c1_high_end", step_out, 1);
         at_cycle(t + rises[i] + 4);
         check("c1_fall", step_out, 0);
      end
      at_cycle(t + 420);
      check("c1_busy_last", busy, 1);
      at_cycle(t + 421);
      check("c1_busy_fall", busy, 0);
      check("c1_dir", dir_out, 1);
      check("c1_irq_off", irq, 0);
      bus_read(3'd5, rd);
      check("c1_status", rd, 32'h2);
      bus_read(3'd6, rd);
      check("c1_position", rd, 6);

      // Case 2: zero steps.
      start_profile(0, 100, 40, 30, 1'b0, t);
      check("c2_step", step_out, 0);
      check("c2_busy", busy, 0);
      bus_read(3'd5, rd);
      check("c2_status", rd, 32'h2);

      // Case 3: MIN above START collapses the ramp to a flat profile.
      start_profile(3, 100, 200, 10, 1'b0, t);
      for (int i = 0; i < 3; i++) check("c3_model_period", m_per[i], 100);
      at_cycle(t + 50);
      bus_read(3'd5, rd);
      check("c3_status_accel", rd, 32'h5);
      at_cycle(t + 101);
      bus_read(3'd5, rd);
      check("c3_status_cruise", rd, 32'h9);
      check("c3_dir", dir_out, 0);
      at_cycle(t + 201);
      check("c3_rise3", step_out, 1);
      wait_idle("c3_idle");
      bus_read(3'd6, rd);
      check("c3_position", rd, 3);

      // Case 4: abort during the second pulse.
      start_profile(6, 100, 40, 30, 1'b1, t);
      at_cycle(t + 101);
      check("c4_pulse2", step_out, 1);
      bus_write(3'd0, 32'h4, 4'hF, e);
      m_abort = e;
      check("c4_step_low", step_out, 0);
      check("c4_busy", busy, 0);
      bus_read(3'd5, rd);
      check("c4_status", rd, 32'h2);
      bus_read(3'd6, rd);
      check("c4_position", rd, 2);
      bus_write(3'd1, 32'd5, 4'hF, e);
      bus_read(3'd1, rd);
      check("c4_steps_accepted", rd, 5);

      // Case 5: byte enables, busy write protection, done clear, irq.
      bus_write(3'd1, 32'h1234_5600, 4'hF, e);
      bus_write(3'd1, 32'h0000_00AB, 4'h1, e);
      bus_read(3'd7, rd);
      check("c5_reg7", rd, 0);
      bus_read(3'd1, rd);
      check("c5_byteenable", rd, 32'h1234_56AB);
      start_profile(6, 100, 40, 30, 1'b1, t);
      bus_write(3'd1, 32'd99, 4'hF, e);
      bus_read(3'd1, rd);
      check("c5_busy_write_ignored", rd, 6);
      wait_idle("c5_idle");
      check("c5_irq_disabled", irq, 0);
      bus_write(3'd0, 32'h8, 4'hF, e);
      check("c5_irq_on", irq, 1);
      bus_read(3'd0, rd);
      check("c5_ctrl_readback", rd, 32'h8);
      bus_write(3'd5, 32'h2, 4'hF, e);
      check("c5_irq_cleared", irq, 0);
      bus_read(3'd5, rd);
      check("c5_done_cleared", rd, 0);
      bus_write(3'd0, 32'h0, 4'hF, e);

      // Case 6: asynchronous reset mid-cruise, then a clean restart.
      start_profile(6, 100, 40, 30, 1'b1, t);
      at_cycle(t + 212);
      check("c6_pre_step", step_out, 1);
      check("c6_pre_dir", dir_out, 1);
      #2;
      rst = 1'b1;
      m_n = 0;
      #1;
      check("c6_async_step", step_out, 0);
      check("c6_async_busy", busy, 0);
      check("c6_async_dir", dir_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int a = 1; a < 7; a++) begin
         bus_read(3'(a), rd);
         check("c6_reg_after_rst", rd, 0);
      end
      start_profile(6, 100, 40, 30, 1'b1, t);
      for (int i = 0; i < 6; i++) begin
         at_cycle(t + rises[i]);
         check("c6_rise", step_out, 1);
      end
      wait_idle("c6_idle");
      bus_read(3'd6, rd);
      check("c6_position", rd, 6);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
